ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-port round-robin arbiter that shares the single synchronous data RAM between the CPU (requester A) and a host/debug loader (requester B).
- Serialises accesses, registers address/data/write-enable, and drives the RAM enable and strobe lines.
- Returns read data to the winning requester with a valid pulse.
- Sits between the CPU RAM port and the RAM macro.

Parameters:
g_RAM_WIDTH, 9, data word width in bits
g_RAM_ADDR, 11, RAM address width in bits

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_a_req  in  1  requester A access request, held until o_a_gnt
i_a_we  in  1  requester A: 1 = write, 0 = read
i_a_addr  in  g_RAM_ADDR  requester A address
i_a_data  in  g_RAM_WIDTH  requester A write data
o_a_gnt  out  1  one-cycle pulse: A's access issued to RAM
o_a_valid  out  1  one-cycle pulse: o_a_data holds A's read result
o_a_data  out  g_RAM_WIDTH  A read data, held until next A read completes
i_b_req, i_b_we, i_b_addr, i_b_data, o_b_gnt, o_b_valid, o_b_data: same as A, for requester B
o_ram_en  out  1  RAM enable
o_ram_we  out  1  RAM write strobe
o_ram_re  out  1  RAM read strobe = o_ram_en & ~o_ram_we
o_ram_addr  out  g_RAM_ADDR  RAM address
o_ram_data  out  g_RAM_WIDTH  RAM write data
i_ram_data  in  g_RAM_WIDTH  RAM read data, valid the cycle after the address edge

Behaviour:
Reset (i_rst_n = 0, asynchronous):
- All outputs 0; state IDLE; last-grant pointer = B, so A wins the first tie.
- Reset mid-operation aborts the access: no gnt or valid pulse is emitted afterwards.

FSM states IDLE, ISSUE, WAIT.

IDLE:
- If no req is set, stay in IDLE; RAM outputs are held at en=0, we=0.
- If exactly one req is set, that requester wins.
- If both are set, the requester not granted last wins.
- On a win: latch the winner's addr, data and we plus a winner id into registers, update the last-grant pointer, and go to ISSUE.

ISSUE (exactly one cycle):
- o_ram_en = 1; o_ram_we = latched we; addr and data come from the latches.
- The winner's o_x_gnt = 1 for this cycle only.
- Write: next state IDLE.
- Read: next state WAIT.

WAIT (one cycle):
- o_ram_en = 0.
- At the closing edge, capture i_ram_data into the winner's o_x_data and pulse o_x_valid for one cycle. The pulse coincides with the following IDLE cycle.
- Next state IDLE.

Timing, with the request first seen in cycle 0:
- gnt is in cycle 1.
- RAM write takes effect at the end of cycle 1.
- Read valid and data are in cycle 3.
- Throughput: one write per 2 cycles, one read per 3 cycles.

Requester rules:
- A requester holds req/we/addr/data stable until it sees gnt, then drops req or presents a new request at the following edge.
- A req raised and dropped while the arbiter is in ISSUE or WAIT is never seen.
- Inputs are sampled only in IDLE.
- While not in ISSUE, o_ram_addr and o_ram_data hold their last latched values.

Fairness:
- Under continuous requests from both, grants strictly alternate A, B, A, B.
- Neither requester is ever granted twice while the other is continuously requesting.

Independence of the two sides:
- A valid pulse for one requester never alters the other's o_x_data.
- o_x_valid and o_x_gnt are never set for both requesters in the same cycle.

Test Plan:
- Reset release, then A write: A write addr 0x005 data 0x1A3. Required: o_a_gnt at cycle 1, and o_ram_en=1, we=1, addr 0x005, data 0x1A3 in that same cycle. Then A read of 0x005. Required: o_a_valid in cycle 3 with o_a_data=0x1A3.
- Simultaneous reads: A reads 0x010, B reads 0x011, both held continuously. Required: grants in the order A, B, A, B. Each valid pulse goes only to its own requester with the correct data; the other's o_x_data is unchanged.
- Single requester back-to-back: B issues 4 writes followed by 4 reads. Required: gnt every 2 cycles for the writes and every 3 cycles for the reads; data read back matches the writes; A outputs stay 0.
- Mid-read reset: assert i_rst_n=0 during WAIT. Required: all outputs 0 immediately, no o_x_valid pulse afterwards, and the first tie after release is granted to A.
- Late request: A req raised only during B's ISSUE cycle and held. Required: A granted in the ISSUE cycle following the next IDLE, with no gnt pulse while the arbiter is in WAIT.
- Strobes: sweep reads and writes. Required: o_ram_re = en & ~we in every cycle, en never high outside ISSUE, and gnt pulses never overlap.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares one synchronous RAM between requester A (CPU) and B (host/debug).
// Each access is IDLE -> ISSUE (-> WAIT for reads). Read data is returned with a one-cycle valid pulse.
module ram_arbiter #(
  parameter int unsigned g_RAM_WIDTH = 9,
  parameter int unsigned g_RAM_ADDR  = 11
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,

  input  logic                   i_a_req,
  input  logic                   i_a_we,
  input  logic [g_RAM_ADDR-1:0]  i_a_addr,
  input  logic [g_RAM_WIDTH-1:0] i_a_data,
  output logic                   o_a_gnt,
  output logic                   o_a_valid,
  output logic [g_RAM_WIDTH-1:0] o_a_data,

  input  logic                   i_b_req,
  input  logic                   i_b_we,
  input  logic [g_RAM_ADDR-1:0]  i_b_addr,
  input  logic [g_RAM_WIDTH-1:0] i_b_data,
  output logic                   o_b_gnt,
  output logic                   o_b_valid,
  output logic [g_RAM_WIDTH-1:0] o_b_data,

  output logic                   o_ram_en,
  output logic                   o_ram_we,
  output logic                   o_ram_re,
  output logic [g_RAM_ADDR-1:0]  o_ram_addr,
  output logic [g_RAM_WIDTH-1:0] o_ram_data,
  input  logic [g_RAM_WIDTH-1:0] i_ram_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                 state_q, state_d;
  logic                   last_b_q, last_b_d;  // 1: B was granted last
  logic                   win_b_q, win_b_d;    // 1: current access belongs to B
  logic                   we_q, we_d;
  logic [g_RAM_ADDR-1:0]  addr_q, addr_d;
  logic [g_RAM_WIDTH-1:0] data_q, data_d;
  logic                   a_valid_q, a_valid_d;
  logic                   b_valid_q, b_valid_d;
  logic [g_RAM_WIDTH-1:0] a_data_q, a_data_d;
  logic [g_RAM_WIDTH-1:0] b_data_q, b_data_d;
  logic                   pick_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      last_b_q  <= 1'b1;
      win_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      win_b_q   <= win_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    win_b_d  = win_b_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    // On a tie the requester that was not granted last wins.
    pick_b   = i_b_req && (!i_a_req || !last_b_q);

    unique case (state_q)
      StIdle: begin
        if (i_a_req || i_b_req) begin
          win_b_d  = pick_b;
          last_b_d = pick_b;
          we_d     = pick_b ? i_b_we   : i_a_we;
          addr_d   = pick_b ? i_b_addr : i_a_addr;
          data_d   = pick_b ? i_b_data : i_a_data;
          state_d  = StIssue;
        end
      end
      StIssue: state_d = we_q ? StIdle : StWait;
      StWait:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Read data arrives during WAIT; capture it at the closing edge for the winner only.
    a_valid_d = (state_q == StWait) && !win_b_q;
    b_valid_d = (state_q == StWait) &&  win_b_q;
    a_data_d  = a_valid_d ? i_ram_data : a_data_q;
    b_data_d  = b_valid_d ? i_ram_data : b_data_q;
  end

  always_comb begin
    o_ram_en   = (state_q == StIssue);
    o_ram_we   = o_ram_en &  we_q;
    o_ram_re   = o_ram_en & ~we_q;
    o_ram_addr = addr_q;
    o_ram_data = data_q;
    o_a_gnt    = o_ram_en & ~win_b_q;
    o_b_gnt    = o_ram_en &  win_b_q;
    o_a_valid  = a_valid_q;
    o_b_valid  = b_valid_q;
    o_a_data   = a_data_q;
    o_b_data   = b_data_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter, with a behavioural synchronous RAM behind the arbiter.
module tb_ram_arbiter;
  localparam int unsigned W  = 9;
  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata, b_wdata;
  logic          a_gnt, a_valid, b_gnt, b_valid;
  logic [W-1:0]  a_rdata, b_rdata;
  logic          en, we, re;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata, ram_rdata;

  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [W-1:0]  wd [4] = '{9'h0C7, 9'h13A, 9'h1FE, 9'h055};
  logic [63:0]   got_v, exp_v;
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  // RAM model: write at the address edge, read data valid the following cycle.
  always @(posedge clk) begin
    if (en) begin
      if (we) mem[ram_addr] <= ram_wdata;
      else    ram_rdata <= mem[ram_addr];
    end
  end

  ram_arbiter #(.g_RAM_WIDTH(W), .g_RAM_ADDR(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_wdata),
    .o_a_gnt(a_gnt), .o_a_valid(a_valid), .o_a_data(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_wdata),
    .o_b_gnt(b_gnt), .o_b_valid(b_valid), .o_b_data(b_rdata),
    .o_ram_en(en), .o_ram_we(we), .o_ram_re(re), .o_ram_addr(ram_addr),
    .o_ram_data(ram_wdata), .i_ram_data(ram_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    clear_inputs();
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    tick();
    got_v = 64'({a_gnt, a_valid, a_rdata, b_gnt, b_valid, b_rdata, en, we, re, ram_addr, ram_wdata});
    exp_v = 64'd0;
    n_checks++;
    if (got_v !== exp_v) $display("FAIL reset_outputs: got %h want %h", got_v, exp_v);
    else n_pass++;
    rst_n = 1;
    tick();
    got_v = 64'({a_gnt, b_gnt, en, we, re, a_valid, b_valid});
    n_checks++;
    if (got_v !== exp_v) $display("FAIL idle_after_reset: got %h want %h", got_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_a_write_read;
    a_req = 1; a_we = 1; a_addr = 11'h005; a_wdata = 9'h1A3;
    tick();
    got_v = 64'({a_gnt, b_gnt, en, we, re, ram_addr, ram_wdata});
    exp_v = 64'({5'b10110, 11'h005, 9'h1A3});
    n_checks++;
    if (got_v !== exp_v) $display("FAIL a_write_issue: got %h want %h", got_v, exp_v);
    else n_pass++;
    a_we = 0;
    tick();
    got_v = 64'({a_gnt, en});
    exp_v = 64'd0;
    n_checks++;
    if (got_v !== exp_v) $display("FAIL a_write_idle: got %h want %h", got_v, exp_v);
    else n_pass++;
    tick();
    got_v = 64'({a_gnt, en, we, re, ram_addr});
    exp_v = 64'({4'b1101, 11'h005});
    n_checks++;
    if (got_v !== exp_v) $display("FAIL a_read_issue: got %h want %h", got_v, exp_v);
    else n_pass++;
    a_req = 0;
    tick();
    got_v = 64'({a_valid, en, a_gnt});
    exp_v = 64'd0;
    n_checks++;
    if (got_v !== exp_v) $display("FAIL a_read_wait: got %h want %h", got_v, exp_v);
    else n_pass++;
    tick();
    got_v = 64'({a_valid, a_rdata, b_valid});
    exp_v = 64'({1'b1, 9'h1A3, 1'b0});
    n_checks++;
    if (got_v !== exp_v) $display("FAIL a_read_valid: got %h want %h", got_v, exp_v);
    else n_pass++;
    tick();
    got_v = 64'({a_valid, a_rdata});
    exp_v = 64'({1'b0, 9'h1A3});
    n_checks++;
    if (got_v !== exp_v) $display("FAIL a_data_hold: got %h want %h", got_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] ea;
    do_reset();
    b_req = 1; b_we = 1; b_addr = 11'h010; b_wdata = wd[0];
    for (int i = 0; i < 4; i++) begin
      ea = AW'(16 + i);
      tick();
      got_v = 64'({b_gnt, a_gnt, en, we, ram_addr, ram_wdata});
      exp_v = 64'({4'b1011, ea, wd[i]});
      n_checks++;
      if (got_v !== exp_v) $display("FAIL b2b_write_gnt%0d: got %h want %h", i, got_v, exp_v);
      else n_pass++;
      if (i < 3) begin
        b_addr = AW'(17 + i); b_wdata = wd[i+1];
      end else begin
        b_we = 0; b_addr = 11'h010;
      end
      tick();
      got_v = 64'({b_gnt, en, a_gnt, a_valid, a_rdata});
      exp_v = 64'd0;
      n_checks++;
      if (got_v !== exp_v) $display("FAIL b2b_write_gap%0d: got %h want %h", i, got_v, exp_v);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      ea = AW'(16 + i);
      tick();
      got_v = 64'({b_gnt, a_gnt, en, re, ram_addr});
      exp_v = 64'({4'b1011, ea});
      n_checks++;
      if (got_v !== exp_v) $display("FAIL b2b_read_gnt%0d: got %h want %h", i, got_v, exp_v);
      else n_pass++;
      if (i < 3) b_addr = AW'(17 + i);
      else       b_req = 0;
      tick();
      got_v = 64'({b_gnt, b_valid, en});
      exp_v = 64'd0;
      n_checks++;
      if (got_v !== exp_v) $display("FAIL b2b_read_wait%0d: got %h want %h", i, got_v, exp_v);
      else n_pass++;
      tick();
      got_v = 64'({b_valid, b_rdata, a_valid, a_gnt, a_rdata});
      exp_v = 64'({1'b1, wd[i], 1'b0, 1'b0, 9'h000});
      n_checks++;
      if (got_v !== exp_v) $display("FAIL b2b_read_data%0d: got %h want %h", i, got_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_simul_reads;
    logic [W-1:0] exp_a, exp_b;
    logic         win_b;
    exp_a = 9'h000;
    exp_b = wd[3];
    a_req = 1; a_we = 0; a_addr = 11'h010;
    b_req = 1; b_we = 0; b_addr = 11'h011;
    for (int k = 0; k < 4; k++) begin
      win_b = (k % 2 == 1);
      tick();
      got_v = 64'({a_gnt, b_gnt});
      exp_v = win_b ? 64'd1 : 64'd2;
      n_checks++;
      if (got_v !== exp_v) $display("FAIL simul_gnt%0d: got %h want %h", k, got_v, exp_v);
      else n_pass++;
      tick();
      got_v = 64'({a_valid, b_valid, a_gnt, b_gnt});
      exp_v = 64'd0;
      n_checks++;
      if (got_v !== exp_v) $display("FAIL simul_wait%0d: got %h want %h", k, got_v, exp_v);
      else n_pass++;
      tick();
      if (win_b) exp_b = wd[1];
      else       exp_a = wd[0];
      got_v = 64'({a_valid, b_valid, a_rdata, b_rdata});
      exp_v = 64'({~win_b, win_b, exp_a, exp_b});
      n_checks++;
      if (got_v !== exp_v) $display("FAIL simul_valid%0d: got %h want %h", k, got_v, exp_v);
      else n_pass++;
    end
    a_req = 0; b_req = 0;
    tick();
  endtask

  task automatic test_late_request;
    b_req = 1; b_we = 0; b_addr = 11'h011;
    tick();
    got_v = 64'({a_gnt, b_gnt});
    exp_v = 64'd1;
    n_checks++;
    if (got_v !== exp_v) $display("FAIL late_b_gnt: got %h want %h", got_v, exp_v);
    else n_pass++;
    b_req = 0;
    a_req = 1; a_we = 0; a_addr = 11'h010;
    tick();
    got_v = 64'({a_gnt, b_gnt, en});
    exp_v = 64'd0;
    n_checks++;
    if (got_v !== exp_v) $display("FAIL late_no_gnt_in_wait: got %h want %h", got_v, exp_v);
    else n_pass++;
    tick();
    got_v = 64'({b_valid, b_rdata, a_gnt, en});
    exp_v = 64'({1'b1, wd[1], 2'b00});
    n_checks++;
    if (got_v !== exp_v) $display("FAIL late_idle: got %h want %h", got_v, exp_v);
    else n_pass++;
    tick();
    got_v = 64'({a_gnt, b_gnt, ram_addr});
    exp_v = 64'({2'b10, 11'h010});
    n_checks++;
    if (got_v !== exp_v) $display("FAIL late_a_gnt: got %h want %h", got_v, exp_v);
    else n_pass++;
    a_req = 0;
    repeat (2) tick();
    got_v = 64'({a_valid, a_rdata, b_valid});
    exp_v = 64'({1'b1, wd[0], 1'b0});
    n_checks++;
    if (got_v !== exp_v) $display("FAIL late_a_valid: got %h want %h", got_v, exp_v);
    else n_pass++;
    tick();
  endtask

  task automatic test_mid_read_reset;
    a_req = 1; a_we = 0; a_addr = 11'h010;
    tick();
    a_req = 0;
    tick();
    rst_n = 0;
    #1;
    got_v = 64'({a_gnt, a_valid, a_rdata, b_gnt, b_valid, b_rdata, en, we, re, ram_addr, ram_wdata});
    exp_v = 64'd0;
    n_checks++;
    if (got_v !== exp_v) $display("FAIL rst_async_clear: got %h want %h", got_v, exp_v);
    else n_pass++;
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got_v = 64'({a_valid, b_valid, a_rdata, a_gnt, b_gnt, en});
      n_checks++;
      if (got_v !== exp_v) $display("FAIL rst_no_valid%0d: got %h want %h", i, got_v, exp_v);
      else n_pass++;
    end
    a_req = 1; a_we = 0; a_addr = 11'h010;
    b_req = 1; b_we = 0; b_addr = 11'h011;
    tick();
    got_v = 64'({a_gnt, b_gnt});
    exp_v = 64'd2;
    n_checks++;
    if (got_v !== exp_v) $display("FAIL rst_first_tie: got %h want %h", got_v, exp_v);
    else n_pass++;
    a_req = 0; b_req = 0;
    repeat (2) tick();
    got_v = 64'({a_valid, a_rdata});
    exp_v = 64'({1'b1, wd[0]});
    n_checks++;
    if (got_v !== exp_v) $display("FAIL rst_tie_data: got %h want %h", got_v, exp_v);
    else n_pass++;
    tick();
  endtask

  task automatic test_strobes;
    int prev = 0;
    int cur;
    int n_gnt = 0;
    a_req = 1; a_we = 1; a_addr = 11'h200; a_wdata = 9'h0AB;
    b_req = 1; b_we = 0; b_addr = 11'h300; b_wdata = 9'h111;
    for (int i = 0; i < 60; i++) begin
      tick();
      got_v = 64'({re, en, a_gnt & b_gnt, a_valid & b_valid});
      exp_v = 64'({en & ~we, a_gnt | b_gnt, 2'b00});
      n_checks++;
      if (got_v !== exp_v) $display("FAIL strobe_cycle%0d: got %h want %h", i, got_v, exp_v);
      else n_pass++;
      if (a_gnt || b_gnt) begin
        cur = a_gnt ? 1 : 2;
        if (prev != 0) begin
          n_checks++;
          if (cur == prev) $display("FAIL fairness%0d: got %0d want %0d", i, cur, 3 - prev);
          else n_pass++;
        end
        prev = cur;
        n_gnt++;
      end
      if (a_gnt) begin
        a_we = ~a_we; a_addr = a_addr + 11'd1; a_wdata = a_wdata + 9'h025;
      end
      if (b_gnt) begin
        b_we = b_addr[1]; b_addr = b_addr + 11'd1; b_wdata = b_wdata + 9'h013;
      end
    end
    a_req = 0; b_req = 0;
    n_checks++;
    if (n_gnt < 16) $display("FAIL strobe_gnt_count: got %0d want >= 16", n_gnt);
    else n_pass++;
    repeat (3) tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_a_write_read();
    test_back_to_back();
    test_simul_reads();
    test_late_request();
    test_mid_read_reset();
    test_strobes();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
